// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// selects and the bundle of per-buffer control strobes.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      FWD_REG   = 2'b00,
      FWD_MEMWB = 2'b01,
      FWD_EXMEM = 2'b10
   } fwd_e;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
      logic memwb_bubble;
      logic dmem_req;
   } ctrl_t;

   // Field order: pc, ifid, idex, exmem, memwb enables; three flushes; bubble; req.
   localparam ctrl_t CTRL_RESET   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam ctrl_t CTRL_ADVANCE = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam ctrl_t CTRL_SQUASH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam ctrl_t CTRL_MEM_HOLD = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   localparam ctrl_t CTRL_HALT    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   // True when a later stage will write the register the EX operand reads.
   function automatic logic produces(input logic reg_write, input logic [4:0] rd,
                                     input logic [4:0] src);
      return reg_write && (rd != 5'd0) && (rd == src);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational EX-stage forwarding selects and load-use hazard detection.
module fwd_unit
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [4:0] ifid_rs,
   input  logic [4:0] ifid_rt,
   input  logic [4:0] idex_rs,
   input  logic [4:0] idex_rt,
   input  logic       idex_mem_read,
   input  logic       exmem_reg_write,
   input  logic [4:0] exmem_rd,
   input  logic       memwb_reg_write,
   input  logic [4:0] memwb_rd,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b,
   output logic       load_use
);

   // NOTE: every output gets a default at the top of always_comb so no path infers a latch.
   always_comb begin
      fwd_a = FWD_REG;
      fwd_b = FWD_REG;
      // EX/MEM is checked last so the younger producer wins.
      if (produces(memwb_reg_write, memwb_rd, idex_rs)) fwd_a = FWD_MEMWB;
      if (produces(exmem_reg_write, exmem_rd, idex_rs)) fwd_a = FWD_EXMEM;
      if (produces(memwb_reg_write, memwb_rd, idex_rt)) fwd_b = FWD_MEMWB;
      if (produces(exmem_reg_write, exmem_rd, idex_rt)) fwd_b = FWD_EXMEM;
   end

   assign load_use = idex_mem_read && (idex_rt != 5'd0) &&
                     ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: buffer enables/flushes, forwarding selects, load-use
// stalls, WB jump squash and a data-memory handshake with timeout.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       I_IFID_Rs,
   input  logic [4:0]       I_IFID_Rt,
   input  logic [4:0]       I_IDEX_Rs,
   input  logic [4:0]       I_IDEX_Rt,
   input  logic             I_IDEX_MemRead,
   input  logic             I_EXMEM_RegWrite,
   input  logic [4:0]       I_EXMEM_Rd,
   input  logic             I_EXMEM_MemAcc,
   input  logic             I_MEMWB_RegWrite,
   input  logic [4:0]       I_MEMWB_Rd,
   input  logic             I_Jump,
   input  logic             I_Dmem_Ack,
   output logic             O_Dmem_Req,
   output logic             O_PC_En,
   output logic             O_IFID_En,
   output logic             O_IDEX_En,
   output logic             O_EXMEM_En,
   output logic             O_MEMWB_En,
   output logic             O_IFID_Flush,
   output logic             O_IDEX_Flush,
   output logic             O_EXMEM_Flush,
   output logic             O_MEMWB_Bubble,
   output logic [1:0]       O_FwdA,
   output logic [1:0]       O_FwdB,
   output logic [CNT_W-1:0] O_Stall_Cnt,
   output logic             O_Timeout
);

   localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

   state_e            state;
   logic [WAIT_W-1:0] wait_cnt;
   ctrl_t             ctrl;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
   logic              load_use;

   fwd_unit u_fwd (
      .ifid_rs         (I_IFID_Rs),
      .ifid_rt         (I_IFID_Rt),
      .idex_rs         (I_IDEX_Rs),
      .idex_rt         (I_IDEX_Rt),
      .idex_mem_read   (I_IDEX_MemRead),
      .exmem_reg_write (I_EXMEM_RegWrite),
      .exmem_rd        (I_EXMEM_Rd),
      .memwb_reg_write (I_MEMWB_RegWrite),
      .memwb_rd        (I_MEMWB_Rd),
      .fwd_a           (fwd_a),
      .fwd_b           (fwd_b),
      .load_use        (load_use)
   );

   // rst_n gates the strobes directly so a mid-wait reset drops the request at once.
   always_comb begin
      ctrl = CTRL_ADVANCE;
      if (!rst_n) begin
         ctrl = CTRL_RESET;
      end else begin
         case (state)
            ST_RUN: begin
               if (I_Jump) begin
                  ctrl = CTRL_SQUASH;
               end else if (I_EXMEM_MemAcc) begin
                  ctrl          = I_Dmem_Ack ? CTRL_ADVANCE : CTRL_MEM_HOLD;
                  ctrl.dmem_req = 1'b1;
               end else if (load_use) begin
                  ctrl.pc_en      = 1'b0;
                  ctrl.ifid_en    = 1'b0;
                  ctrl.idex_flush = 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               ctrl          = I_Dmem_Ack ? CTRL_ADVANCE : CTRL_MEM_HOLD;
               ctrl.dmem_req = 1'b1;
            end
            default: ctrl = CTRL_HALT;
         endcase
      end
   end

   assign O_PC_En        = ctrl.pc_en;
   assign O_IFID_En      = ctrl.ifid_en;
   assign O_IDEX_En      = ctrl.idex_en;
   assign O_EXMEM_En     = ctrl.exmem_en;
   assign O_MEMWB_En     = ctrl.memwb_en;
   assign O_IFID_Flush   = ctrl.ifid_flush;
   assign O_IDEX_Flush   = ctrl.idex_flush;
   assign O_EXMEM_Flush  = ctrl.exmem_flush;
   assign O_MEMWB_Bubble = ctrl.memwb_bubble;
   assign O_Dmem_Req     = ctrl.dmem_req;
   assign O_FwdA         = rst_n ? fwd_a : 2'b00;
   assign O_FwdB         = rst_n ? fwd_b : 2'b00;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         wait_cnt    <= '0;
         O_Stall_Cnt <= '0;
         O_Timeout   <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (!I_Jump && I_EXMEM_MemAcc && !I_Dmem_Ack) begin
                  state    <= ST_MEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
               end
            end
            ST_MEM_WAIT: begin
               if (I_Dmem_Ack) begin
                  state    <= ST_RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                  state     <= ST_HALT;
                  O_Timeout <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            default: state <= ST_HALT;
         endcase

         if (!ctrl.pc_en && (O_Stall_Cnt != '1)) begin
            O_Stall_Cnt <= O_Stall_Cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 4;
   localparam int STALL_MAX   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [4:0]       ifid_rs, ifid_rt, idex_rs, idex_rt, exmem_rd, memwb_rd;
   logic             idex_memread, exmem_rw, exmem_memacc, memwb_rw, jump, ack;
   logic             dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic             ifid_flush, idex_flush, exmem_flush, memwb_bubble, timeout;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cnt;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .I_IFID_Rs(ifid_rs), .I_IFID_Rt(ifid_rt), .I_IDEX_Rs(idex_rs), .I_IDEX_Rt(idex_rt),
      .I_IDEX_MemRead(idex_memread), .I_EXMEM_RegWrite(exmem_rw), .I_EXMEM_Rd(exmem_rd),
      .I_EXMEM_MemAcc(exmem_memacc), .I_MEMWB_RegWrite(memwb_rw), .I_MEMWB_Rd(memwb_rd),
      .I_Jump(jump), .I_Dmem_Ack(ack), .O_Dmem_Req(dmem_req),
      .O_PC_En(pc_en), .O_IFID_En(ifid_en), .O_IDEX_En(idex_en), .O_EXMEM_En(exmem_en),
      .O_MEMWB_En(memwb_en), .O_IFID_Flush(ifid_flush), .O_IDEX_Flush(idex_flush),
      .O_EXMEM_Flush(exmem_flush), .O_MEMWB_Bubble(memwb_bubble),
      .O_FwdA(fwd_a), .O_FwdB(fwd_b), .O_Stall_Cnt(stall_cnt), .O_Timeout(timeout)
   );

   typedef struct packed {
      logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt;
      logic       idex_memread, exmem_rw;
      logic [4:0] exmem_rd;
      logic       exmem_memacc, memwb_rw;
      logic [4:0] memwb_rd;
      logic       jump, ack;
   } in_t;

   // en = {pc, ifid, idex, exmem, memwb}; fl = {ifid, idex, exmem flush, memwb bubble}
   typedef struct packed {
      logic [4:0] en;
      logic [3:0] fl;
      logic       req;
      logic [1:0] fa, fb;
   } out_t;

   typedef struct packed {
      in_t  in;
      out_t exp;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: pipeline mode (0 running, 1 waiting on memory, 2 halted).
   int m_mode, m_waited, m_stall;
   bit m_tmo;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic in_t mk(input int i_rs, input int i_rt, input int x_rs, input int x_rt,
                              input bit mrd, input bit ew, input int ed, input bit macc,
                              input bit ww, input int wd, input bit jmp, input bit ak);
      in_t v;
      v.ifid_rs = 5'(i_rs); v.ifid_rt = 5'(i_rt); v.idex_rs = 5'(x_rs); v.idex_rt = 5'(x_rt);
      v.idex_memread = mrd; v.exmem_rw = ew; v.exmem_rd = 5'(ed); v.exmem_memacc = macc;
      v.memwb_rw = ww; v.memwb_rd = 5'(wd); v.jump = jmp; v.ack = ak;
      return v;
   endfunction

   function automatic out_t mk_out(input logic [4:0] en, input logic [3:0] fl, input logic req,
                                   input logic [1:0] fa, input logic [1:0] fb);
      out_t o;
      o.en = en; o.fl = fl; o.req = req; o.fa = fa; o.fb = fb;
      return o;
   endfunction

   task automatic drive(input in_t v);
      ifid_rs = v.ifid_rs; ifid_rt = v.ifid_rt; idex_rs = v.idex_rs; idex_rt = v.idex_rt;
      idex_memread = v.idex_memread; exmem_rw = v.exmem_rw; exmem_rd = v.exmem_rd;
      exmem_memacc = v.exmem_memacc; memwb_rw = v.memwb_rw; memwb_rd = v.memwb_rd;
      jump = v.jump; ack = v.ack;
   endtask

   function automatic out_t sample();
      return mk_out({pc_en, ifid_en, idex_en, exmem_en, memwb_en},
                    {ifid_flush, idex_flush, exmem_flush, memwb_bubble}, dmem_req, fwd_a, fwd_b);
   endfunction

   // Youngest in-flight producer of a non-zero register supplies the operand.
   function automatic logic [1:0] pick(input in_t v, input logic [4:0] src);
      if (src == 0) return 2'd0;
      if (v.exmem_rw && v.exmem_rd == src) return 2'd2;
      if (v.memwb_rw && v.memwb_rd == src) return 2'd1;
      return 2'd0;
   endfunction

   function automatic out_t model_out(input in_t v);
      out_t o = mk_out(5'b11111, 4'b0000, 1'b0, pick(v, v.idex_rs), pick(v, v.idex_rt));
      if (m_mode == 2) begin
         o.en = 5'b00000; o.fl = 4'b0001;
      end else if (m_mode == 1 || (!v.jump && v.exmem_memacc)) begin
         o.req = 1'b1;
         if (!v.ack) begin o.en = 5'b00001; o.fl = 4'b0001; end
      end else if (v.jump) begin
         o.fl = 4'b1111;
      end else if (v.idex_memread && v.idex_rt != 0 &&
                   (v.idex_rt == v.ifid_rs || v.idex_rt == v.ifid_rt)) begin
         o.en = 5'b00111; o.fl = 4'b0100;
      end
      return o;
   endfunction

   function automatic void model_step(input in_t v, input logic pc_on);
      if (m_mode == 0) begin
         if (!v.jump && v.exmem_memacc && !v.ack) begin m_mode = 1; m_waited = 1; end
      end else if (m_mode == 1) begin
         if (v.ack) m_mode = 0;
         else if (m_waited == MEM_TIMEOUT) begin m_mode = 2; m_tmo = 1; end
         else m_waited++;
      end
      if (!pc_on) m_stall = (m_stall < STALL_MAX) ? m_stall + 1 : STALL_MAX;
   endfunction

   // One clock: drive at negedge, sample 1 ns later, check registered outputs, advance model.
   task automatic step(input in_t v, output out_t act, output out_t exp);
      @(negedge clk);
      drive(v);
      #1;
      act = sample();
      exp = model_out(v);
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("timeout", 32'(timeout), 32'(m_tmo));
      model_step(v, exp.en[4]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(mk(8, 8, 8, 8, 1, 1, 8, 1, 1, 8, 1, 0));
      #1;
      check("reset_ctrl", 32'(sample()), 32'(mk_out(5'b00000, 4'b1111, 1'b0, 2'b00, 2'b00)));
      check("reset_stall", 32'(stall_cnt), 32'd0);
      check("reset_timeout", 32'(timeout), 32'd0);
      m_mode = 0; m_waited = 0; m_stall = 0; m_tmo = 0;
      @(negedge clk);
      drive('0);
      rst_n = 1'b1;
   endtask

   function automatic in_t rand_in();
      in_t v;
      v.ifid_rs = 5'($urandom_range(0, 3)); v.ifid_rt = 5'($urandom_range(0, 3));
      v.idex_rs = 5'($urandom_range(0, 3)); v.idex_rt = 5'($urandom_range(0, 3));
      v.exmem_rd = 5'($urandom_range(0, 3)); v.memwb_rd = 5'($urandom_range(0, 3));
      v.idex_memread = ($urandom_range(0, 2) == 0);
      v.exmem_rw = $urandom_range(0, 1); v.memwb_rw = $urandom_range(0, 1);
      v.exmem_memacc = ($urandom_range(0, 3) == 0);
      v.jump = ($urandom_range(0, 7) == 0);
      v.ack = $urandom_range(0, 1);
      return v;
   endfunction

   vec_t tbl[12];
   out_t act, exp;
   in_t  idle, macc_wait, macc_ack;

   initial begin
      idle      = '0;
      macc_wait = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      macc_ack  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      drive(idle);

      //               ifid rs rt, idex rs rt, mrd, exmem rw rd, macc, memwb rw rd, jmp, ack
      tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(5'b11111, 4'b0000, 0, 2'd0, 2'd0)};
      tbl[1]  = '{mk(8, 3, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0), mk_out(5'b00111, 4'b0100, 0, 2'd0, 2'd0)};
      tbl[2]  = '{mk(3, 9, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0), mk_out(5'b00111, 4'b0100, 0, 2'd0, 2'd0)};
      tbl[3]  = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), mk_out(5'b11111, 4'b0000, 0, 2'd0, 2'd0)};
      tbl[4]  = '{mk(0, 0, 8, 8, 0, 1, 8, 0, 1, 8, 0, 0), mk_out(5'b11111, 4'b0000, 0, 2'd2, 2'd2)};
      tbl[5]  = '{mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0), mk_out(5'b11111, 4'b0000, 0, 2'd0, 2'd0)};
      tbl[6]  = '{mk(0, 0, 5, 6, 0, 1, 6, 0, 1, 5, 0, 0), mk_out(5'b11111, 4'b0000, 0, 2'd1, 2'd2)};
      tbl[7]  = '{mk(0, 0, 5, 7, 0, 0, 5, 0, 1, 5, 0, 0), mk_out(5'b11111, 4'b0000, 0, 2'd1, 2'd0)};
      tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), mk_out(5'b11111, 4'b0000, 1, 2'd0, 2'd0)};
      tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0), mk_out(5'b11111, 4'b1111, 0, 2'd0, 2'd0)};
      tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(5'b11111, 4'b0000, 0, 2'd0, 2'd0)};
      tbl[11] = '{mk(4, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1, 0), mk_out(5'b11111, 4'b1111, 0, 2'd0, 2'd0)};

      do_reset();
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].in, act, exp);
         check($sformatf("vec%0d", i), 32'(act), 32'(tbl[i].exp));
      end

      // Load-use stalls exactly one cycle and counts once.
      do_reset();
      step(tbl[1].in, act, exp);
      check("lu_pc_en", 32'(act.en[4]), 32'd0);
      check("lu_idex_flush", 32'(act.fl[2]), 32'd1);
      step(idle, act, exp);
      check("lu_release", 32'(act.en), 32'h1f);
      check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

      // Three cycles without ack, then ack.
      do_reset();
      for (int c = 1; c <= 4; c++) begin
         step((c == 4) ? macc_ack : macc_wait, act, exp);
         check($sformatf("mw_req_c%0d", c), 32'(act.req), 32'd1);
         check($sformatf("mw_exmem_en_c%0d", c), 32'(act.en[1]), (c == 4) ? 32'd1 : 32'd0);
         check($sformatf("mw_memwb_c%0d", c), 32'({act.en[0], act.fl[0]}), (c == 4) ? 32'd2 : 32'd3);
      end
      step(idle, act, exp);
      check("mw_run", 32'(act), 32'(mk_out(5'b11111, 4'b0000, 0, 2'd0, 2'd0)));
      check("mw_stall_cnt", 32'(stall_cnt), 32'd3);

      // Reset asserted mid-wait drops the request without a clock edge.
      do_reset();
      step(macc_wait, act, exp);
      step(macc_wait, act, exp);
      check("rw_req_before", 32'(act.req), 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rw_req_async", 32'(dmem_req), 32'd0);
      check("rw_stall_async", 32'(stall_cnt), 32'd0);
      m_mode = 0; m_waited = 0; m_stall = 0; m_tmo = 0;
      @(negedge clk);
      drive(idle);
      rst_n = 1'b1;
      step(idle, act, exp);
      check("rw_run", 32'(act.en), 32'h1f);
      check("rw_stall_cnt", 32'(stall_cnt), 32'd0);

      // Ack never arrives: halt after the fifth stalled cycle, then saturate the counter.
      for (int c = 1; c <= 6; c++) begin
         step(macc_wait, act, exp);
         check($sformatf("to_req_c%0d", c), 32'(act.req), (c <= 5) ? 32'd1 : 32'd0);
      end
      check("to_timeout", 32'(timeout), 32'd1);
      check("to_halt_en", 32'(act.en), 32'd0);
      check("to_stall_cnt", 32'(stall_cnt), 32'd5);
      for (int c = 0; c < 20; c++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), act, exp);
      check("sat_stall_cnt", 32'(stall_cnt), 32'(STALL_MAX));
      check("sat_halt_ctrl", 32'({act.en, act.fl, act.req}), 32'({5'b0, 4'b0001, 1'b0}));

      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 49) do_reset();
         step(rand_in(), act, exp);
         check("rand_ctrl", 32'(act), 32'(exp));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
